wb_regfile_slave: RTL and testbench
===================================

Name: wb_regfile_slave

Overview:
- Parametrised Wishbone B4 pipelined slave. It holds a register file of NREGS words with byte-lane writes.
- Register 0 drives the board LEDs directly.
- Programmable wait states, out-of-range address detection, and clean abort when the master drops CYC.
- Sits on the bus interconnect as a generic control/status peripheral.

Parameters:
- ADDR_W, 30, word address width of i_wb_addr
- DATA_W, 32, data bus width; multiple of 8
- NREGS, 16, number of registers, 2..256; index = i_wb_addr[7:0]; upper bits must be 0
- LED_W, 8, LED output width, <= DATA_W
- WAIT_CYCLES, 0, extra cycles inserted before ack, 0..15

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous reset, active-low
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- i_wb_we  in  1  1 = write
- i_wb_addr  in  ADDR_W  word address
- i_wb_data  in  DATA_W  write data
- i_wb_sel  in  DATA_W/8  byte enables
- o_wb_stall  out  1  slave cannot accept a request this cycle
- o_wb_ack  out  1  normal completion, one-cycle pulse
- o_wb_err  out  1  error completion, one-cycle pulse
- o_wb_data  out  DATA_W  read data, valid with ack
- o_leds  out  LED_W  = reg[0][LED_W-1:0]

Behaviour:
- Reset (i_rst_n=0 at posedge): all registers 0, o_wb_ack=0, o_wb_err=0, o_wb_stall=0, o_wb_data=0, state IDLE, wait counter 0.
- Reset mid-transaction: the pending transaction is discarded, with no ack or err.
- Accept condition: i_wb_cyc & i_wb_stb & !o_wb_stall at a posedge.
- Out-of-range: i_wb_addr >= NREGS.
- Writes commit at the accept edge. Only lanes with i_wb_sel[k]=1 are updated. sel=0 is a legal no-op write that still acks.
- Reads sample the register at the accept edge and present it on o_wb_data in the ack cycle. o_wb_data holds its value until the next read completes.
- o_leds follows reg[0] combinationally from the register. It changes the cycle after the accepting edge, with no extra lag.
- WAIT_CYCLES=0:
  - o_wb_stall is held 0.
  - ack/err is asserted the cycle after acceptance.
  - Back-to-back accepts give back-to-back acks, one per cycle, in order.
- WAIT_CYCLES=N>0, FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: stall=0; on accept go to WAIT, counter=N-1.
  - WAIT: stall=1; decrement counter; at 0 go to RESP.
  - RESP: stall=1; assert ack or err for 1 cycle; go to IDLE.
  - Ack therefore arrives N+1 cycles after acceptance, with one outstanding request max.
- CYC dropped in WAIT or RESP: return to IDLE next cycle with no ack/err. A write already committed stays committed.
- ack and err are never high together, and never asserted while i_wb_cyc=0.
- Read-after-write to the same address in consecutive accepts returns the new data.

Optional Feature:
- Macro: WBRF_ERR_EN.
- Defined:
  - Out-of-range access completes with o_wb_err=1, o_wb_ack=0.
  - Writes are dropped.
  - o_wb_data is unchanged.
- Undefined:
  - o_wb_err is tied 0.
  - Out-of-range access completes with ack.
  - Reads return 0; writes are dropped.

Test Plan:
- Reset, then read addr 0..3 -> ack each, o_wb_data=0, o_leds=0x00, stall=0.
- WAIT=0: write 0xDEADBEEF to addr 0 with sel=4'b1111, then read addr 0 next cycle -> two consecutive ack pulses, read data 0xDEADBEEF, o_leds=0xEF.
- Byte lanes: write 0x11223344 to addr 5 with sel=4'b0101, starting from 0 -> read returns 0x00220044.
- WAIT=3: single read -> stall high for 4 cycles after accept, ack exactly 4 cycles after accept; a second stb held during stall is accepted only after stall drops.
- Addr 20 with NREGS=16 -> with WBRF_ERR_EN: err pulse, no ack, regs unchanged; without: ack, data 0.
- WAIT=3: drop cyc 1 cycle after a write accept -> no ack/err, stall=0 within 1 cycle; a subsequent read of the same address returns the written data.

Source files
------------

// File: rtl/wb_regfile_slave.sv
// Wishbone B4 pipelined register-file slave with byte lanes, optional wait states and abort.
// Define WBRF_ERR_EN to complete out-of-range accesses with err instead of ack.
module wb_regfile_slave #(
   parameter int unsigned ADDR_W      = 30,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NREGS       = 16,
   parameter int unsigned LED_W       = 8,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic                  i_wb_we,
   input  logic [ADDR_W-1:0]     i_wb_addr,
   input  logic [DATA_W-1:0]     i_wb_data,
   input  logic [DATA_W/8-1:0]   i_wb_sel,
   output logic                  o_wb_stall,
   output logic                  o_wb_ack,
   output logic                  o_wb_err,
   output logic [DATA_W-1:0]     o_wb_data,
   output logic [LED_W-1:0]      o_leds
);

   localparam int unsigned NLANES = DATA_W / 8;
   localparam int unsigned IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;

`ifdef WBRF_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic              pend_rd_q, pend_err_q;
   logic [DATA_W-1:0] pend_data_q, dout_q;
   logic              accept, in_range, resp_live, rd_done;
   logic [IDX_W-1:0]  idx;

   assign o_wb_stall = (WAIT_CYCLES != 0) && (state_q != StIdle);
   assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
   assign in_range   = (i_wb_addr < ADDR_W'(NREGS));
   assign idx        = i_wb_addr[IDX_W-1:0];

   // Responses are gated by cyc so an abort in the response cycle is silent.
   assign resp_live = (state_q == StResp) & i_wb_cyc;
   assign rd_done   = resp_live & pend_rd_q & ~pend_err_q;

   assign o_wb_ack  = resp_live & ~pend_err_q;
`ifdef WBRF_ERR_EN
   assign o_wb_err  = resp_live & pend_err_q;
`else
   assign o_wb_err  = 1'b0;
`endif
   assign o_wb_data = rd_done ? pend_data_q : dout_q;
   assign o_leds    = regs_q[0][LED_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         StWait: begin
            if (!i_wb_cyc) begin
               state_d = StIdle;
            end else if (cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         // Only reachable with accept=1 when there are no wait states (pipelined acks).
         StResp:  state_d = accept ? StResp : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         pend_rd_q   <= 1'b0;
         pend_err_q  <= 1'b0;
         pend_data_q <= '0;
         dout_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            pend_rd_q   <= ~i_wb_we;
            pend_err_q  <= ErrEn & ~in_range;
            pend_data_q <= in_range ? regs_q[idx] : '0;
         end
         if (rd_done) begin
            dout_q <= pend_data_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (accept && i_wb_we && in_range) begin
         for (int k = 0; k < int'(NLANES); k++) begin
            if (i_wb_sel[k]) begin
               regs_q[idx][8*k +: 8] <= i_wb_data[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Bench for wb_regfile_slave: one zero-wait instance and one three-wait instance,
// checked against an array-based model of the register file.
module tb_wb_regfile_slave;

   localparam int unsigned AW = 30;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 16;
   localparam int unsigned LW = 8;
   localparam int unsigned NW = 3;

`ifdef WBRF_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, cyc0, cyc3, stb, we;
   logic [AW-1:0]  addr;
   logic [DW-1:0]  wdata;
   logic [DW/8-1:0] sel;

   logic           stall0, ack0, err0, stall3, ack3, err3;
   logic [DW-1:0]  rdata0, rdata3;
   logic [LW-1:0]  leds0, leds3;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] mem [2][NR];
   logic [31:0] exp_rd [2];

   wb_regfile_slave #(.ADDR_W(AW), .DATA_W(DW), .NREGS(NR), .LED_W(LW), .WAIT_CYCLES(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc0), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall0),
      .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_data(rdata0), .o_leds(leds0)
   );

   wb_regfile_slave #(.ADDR_W(AW), .DATA_W(DW), .NREGS(NR), .LED_W(LW), .WAIT_CYCLES(NW)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc3), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall3),
      .o_wb_ack(ack3), .o_wb_err(err3), .o_wb_data(rdata3), .o_leds(leds3)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r = old;
      for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   // Reference behaviour of one accepted request on model u.
   task automatic model(input int u, input logic w, input int a, input logic [31:0] d,
                        input logic [3:0] s, output logic eack, output logic eerr);
      bit inr = (a < int'(NR));
      eerr = ERR && !inr;
      eack = !eerr;
      if (w) begin
         if (inr) mem[u][a] = merge(mem[u][a], d, s);
      end else if (eack) begin
         exp_rd[u] = inr ? mem[u][a] : 32'h0;
      end
   endtask

   task automatic drive(input logic w, input int a, input logic [31:0] d, input logic [3:0] s);
      we = w; addr = AW'(a); wdata = d; sel = s; stb = 1'b1;
   endtask

   task automatic tx0(input logic w, input int a, input logic [31:0] d, input logic [3:0] s,
                      output logic ack_o, output logic err_o, output logic [31:0] rd_o);
      @(posedge clk); #1;
      cyc0 = 1'b1;
      drive(w, a, d, s);
      @(posedge clk); #1;
      stb = 1'b0;
      @(negedge clk);
      ack_o = ack0; err_o = err0; rd_o = rdata0;
      @(posedge clk); #1;
      cyc0 = 1'b0;
   endtask

   task automatic tx3(input logic w, input int a, input logic [31:0] d, input logic [3:0] s,
                      output logic ack_o, output logic err_o, output logic [31:0] rd_o,
                      output int lat);
      ack_o = 1'b0; err_o = 1'b0; rd_o = '0; lat = -1;
      @(posedge clk); #1;
      cyc3 = 1'b1;
      drive(w, a, d, s);
      @(posedge clk); #1;
      stb = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack3 || err3) begin
            ack_o = ack3; err_o = err3; rd_o = rdata3; lat = i;
            break;
         end
      end
      @(posedge clk); #1;
      cyc3 = 1'b0;
   endtask

   task automatic test_reset();
      logic ea, ee, a, e;
      logic [31:0] rd;
      rst_n = 1'b0; cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; sel = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int u = 0; u < 2; u++) begin
         exp_rd[u] = '0;
         for (int i = 0; i < int'(NR); i++) mem[u][i] = '0;
      end
      @(negedge clk);
      n_cmp++;
      if ({stall0, ack0, err0, stall3, ack3, err3} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000", {stall0, ack0, err0, stall3, ack3, err3});
      end
      n_cmp++;
      if ({rdata0, rdata3} !== 64'h0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h expected 0", rdata0, rdata3);
      end
      n_cmp++;
      if ({leds0, leds3} !== 16'h0) begin
         n_fail++; $display("FAIL reset_leds: got %h/%h expected 0", leds0, leds3);
      end
      for (int i = 0; i < 4; i++) begin
         tx0(1'b0, i, 32'h0, 4'hF, a, e, rd);
         model(0, 1'b0, i, 32'h0, 4'hF, ea, ee);
         n_cmp++;
         if ({a, e} !== {ea, ee} || rd !== exp_rd[0] || leds0 !== 8'h00 || stall0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read%0d: got ack=%b err=%b d=%h leds=%h stall=%b expected ack=1 d=%h leds=0",
                     i, a, e, rd, leds0, stall0, exp_rd[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic ea, ee;
      @(posedge clk); #1;
      cyc0 = 1'b1;
      drive(1'b1, 0, 32'hDEADBEEF, 4'hF);
      @(posedge clk);
      model(0, 1'b1, 0, 32'hDEADBEEF, 4'hF, ea, ee);
      #1 drive(1'b0, 0, 32'h0, 4'hF);
      @(negedge clk);
      n_cmp++;
      if ({ack0, err0} !== {ea, ee}) begin
         n_fail++; $display("FAIL b2b_write_ack: got %b%b expected %b%b", ack0, err0, ea, ee);
      end
      @(posedge clk);
      model(0, 1'b0, 0, 32'h0, 4'hF, ea, ee);
      #1 stb = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ack0 !== 1'b1 || rdata0 !== exp_rd[0] || rdata0 !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL b2b_read: got ack=%b d=%h expected ack=1 d=deadbeef", ack0, rdata0);
      end
      n_cmp++;
      if (leds0 !== 8'hEF) begin
         n_fail++; $display("FAIL b2b_leds: got %h expected ef", leds0);
      end
      @(posedge clk); #1;
      cyc0 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ack0 !== 1'b0) begin
         n_fail++; $display("FAIL b2b_ack_pulse: got %b expected 0", ack0);
      end
   endtask

   task automatic test_byte_lanes();
      logic a, e, ea, ee;
      logic [31:0] rd;
      tx0(1'b1, 5, 32'h11223344, 4'b0101, a, e, rd);
      model(0, 1'b1, 5, 32'h11223344, 4'b0101, ea, ee);
      tx0(1'b0, 5, 32'h0, 4'hF, a, e, rd);
      model(0, 1'b0, 5, 32'h0, 4'hF, ea, ee);
      n_cmp++;
      if (a !== 1'b1 || rd !== 32'h00220044 || rd !== exp_rd[0]) begin
         n_fail++; $display("FAIL byte_lanes: got ack=%b d=%h expected ack=1 d=00220044", a, rd);
      end
   endtask

   task automatic test_random_b2b();
      logic ea, ee, rw;
      int ra;
      logic [31:0] rdat;
      logic [3:0] rs;
      @(posedge clk); #1;
      cyc0 = 1'b1;
      rw = 1'($urandom); ra = int'($urandom_range(0, 19)); rdat = $urandom;
      rs = 4'($urandom_range(0, 15));
      drive(rw, ra, rdat, rs);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         model(0, rw, ra, rdat, rs, ea, ee);
         #1;
         if (i < 39) begin
            rw = 1'($urandom); ra = int'($urandom_range(0, 19)); rdat = $urandom;
            rs = 4'($urandom_range(0, 15));
            drive(rw, ra, rdat, rs);
         end else begin
            stb = 1'b0;
         end
         @(negedge clk);
         n_cmp++;
         if ({ack0, err0} !== {ea, ee} || rdata0 !== exp_rd[0] || leds0 !== mem[0][0][7:0]) begin
            n_fail++;
            $display("FAIL rand%0d: got ack=%b err=%b d=%h leds=%h expected ack=%b err=%b d=%h leds=%h",
                     i, ack0, err0, rdata0, leds0, ea, ee, exp_rd[0], mem[0][0][7:0]);
         end
      end
      @(posedge clk); #1;
      cyc0 = 1'b0;
   endtask

   task automatic test_wait_states();
      logic a, e, ea, ee, exp_ack, exp_stall;
      logic [31:0] rd, y;
      int lat;
      y = $urandom;
      tx3(1'b1, 2, 32'hA5A5_0F0F, 4'hF, a, e, rd, lat);
      model(1, 1'b1, 2, 32'hA5A5_0F0F, 4'hF, ea, ee);
      n_cmp++;
      if (lat !== int'(NW) + 1 || a !== 1'b1) begin
         n_fail++; $display("FAIL wait_latency: got lat=%0d ack=%b expected lat=%0d ack=1", lat, a, NW + 1);
      end
      // Write then read held on stb: second request waits out the stall.
      @(posedge clk); #1;
      cyc3 = 1'b1;
      drive(1'b1, 9, y, 4'hF);
      @(posedge clk);
      model(1, 1'b1, 9, y, 4'hF, ea, ee);
      #1 drive(1'b0, 9, 32'h0, 4'hF);
      for (int i = 1; i <= 2 * int'(NW) + 4; i++) begin
         @(negedge clk);
         exp_stall = (i <= int'(NW) + 1) || (i >= int'(NW) + 3 && i <= 2 * int'(NW) + 3);
         exp_ack   = (i == int'(NW) + 1) || (i == 2 * int'(NW) + 3);
         n_cmp++;
         if ({stall3, ack3, err3} !== {exp_stall, exp_ack, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_cyc%0d: got stall=%b ack=%b err=%b expected stall=%b ack=%b err=0",
                     i, stall3, ack3, err3, exp_stall, exp_ack);
         end
         if (i == 2 * int'(NW) + 3) begin
            n_cmp++;
            if (rdata3 !== exp_rd[1]) begin
               n_fail++; $display("FAIL wait_raw_data: got %h expected %h", rdata3, exp_rd[1]);
            end
         end
         @(posedge clk);
         if (i == int'(NW) + 2) begin
            model(1, 1'b0, 9, 32'h0, 4'hF, ea, ee);
            #1 stb = 1'b0;
         end
      end
      #1 cyc3 = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic a, e, ea, ee;
      logic [31:0] rd;
      tx0(1'b0, 20, 32'h0, 4'hF, a, e, rd);
      model(0, 1'b0, 20, 32'h0, 4'hF, ea, ee);
      n_cmp++;
      if ({a, e} !== {ea, ee} || rd !== exp_rd[0]) begin
         n_fail++; $display("FAIL oor_read: got ack=%b err=%b d=%h expected ack=%b err=%b d=%h",
                            a, e, rd, ea, ee, exp_rd[0]);
      end
      tx0(1'b1, 20, 32'hCAFEF00D, 4'hF, a, e, rd);
      model(0, 1'b1, 20, 32'hCAFEF00D, 4'hF, ea, ee);
      n_cmp++;
      if ({a, e} !== {ea, ee}) begin
         n_fail++; $display("FAIL oor_write: got ack=%b err=%b expected ack=%b err=%b", a, e, ea, ee);
      end
      tx0(1'b0, 4, 32'h0, 4'hF, a, e, rd);
      model(0, 1'b0, 4, 32'h0, 4'hF, ea, ee);
      n_cmp++;
      if (a !== 1'b1 || rd !== exp_rd[0]) begin
         n_fail++; $display("FAIL oor_alias: got ack=%b d=%h expected ack=1 d=%h", a, rd, exp_rd[0]);
      end
   endtask

   task automatic test_abort();
      logic a, e, ea, ee;
      logic [31:0] rd, v;
      int lat;
      v = $urandom;
      @(posedge clk); #1;
      cyc3 = 1'b1;
      drive(1'b1, 7, v, 4'hF);
      @(posedge clk);
      model(1, 1'b1, 7, v, 4'hF, ea, ee);
      #1 stb = 1'b0;
      @(posedge clk); #1;
      cyc3 = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({ack3, err3} !== 2'b00 || (i >= 3 && stall3 !== 1'b0)) begin
            n_fail++; $display("FAIL abort_cyc%0d: got ack=%b err=%b stall=%b expected 0 0 %s",
                               i, ack3, err3, stall3, (i >= 3) ? "0" : "x");
         end
      end
      tx3(1'b0, 7, 32'h0, 4'hF, a, e, rd, lat);
      model(1, 1'b0, 7, 32'h0, 4'hF, ea, ee);
      n_cmp++;
      if (a !== 1'b1 || rd !== exp_rd[1] || lat !== int'(NW) + 1) begin
         n_fail++; $display("FAIL abort_readback: got ack=%b d=%h lat=%0d expected ack=1 d=%h lat=%0d",
                            a, rd, lat, exp_rd[1], NW + 1);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_byte_lanes();
      test_random_b2b();
      test_wait_states();
      test_out_of_range();
      test_abort();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
